alu_sequencer: RTL
==================

# alu_sequencer

Fetch/decode/execute controller for the 8-bit processor: it reads instruction bytes from a synchronous instruction ROM and drives the ALU's operand and control inputs (A, B, ALUCtrl). It captures the ALU result into an accumulator or into a 4-entry register file. This block is the producer side of the ALU interface; the ALU itself (combinational: ALUCtrl 0 → B, ALUCtrl 1 → A+B mod 256) sits outside and is instantiated alongside it.

## Interface
- No parameters. All datapaths are 8 bits wide.
- `clk` input 1 — single clock; everything is rising-edge.
- `rst` input 1 — asynchronous, active-high reset.
- `imem_addr` output 8 — ROM byte address.
- `imem_rd` output 1 — ROM read strobe.
- `imem_data` input 8 — ROM data, valid the cycle after `imem_rd`.
- `alu_a` output 8 — ALU operand A; always equals `acc`.
- `alu_b` output 8 — ALU operand B.
- `alu_ctrl` output 1 — 0 = pass B, 1 = A+B.
- `alu_out` input 8 — combinational ALU result.
- `acc` output 8 — accumulator.
- `pc` output 8 — program counter.
- `retire` output 1 — one-cycle pulse when an instruction completes.
- `halted` output 1 — high in the HALT state.

## Operation
- Opcode is `ir[7:5]`; register index `r` is `ir[1:0]`; bits `[4:2]` are ignored.
  - 000 NOP
  - 001 LDI imm: acc = imm
  - 010 ADDI imm: acc = acc + imm
  - 011 LDR r: acc = reg[r]
  - 100 ADDR r: acc = acc + reg[r]
  - 101 STR r: reg[r] = acc
  - 110 JMP addr: pc = addr
  - 111 HALT
- LDI, ADDI and JMP are 2-byte instructions; the second byte is the immediate or address.
- All acc/reg writes go through the ALU:
  - LDI: B = imm, ctrl 0.
  - ADDI: B = imm, ctrl 1.
  - LDR: B = reg[r], ctrl 0.
  - ADDR: B = reg[r], ctrl 1.
  - STR: B = acc, ctrl 0, `alu_out` written to reg[r].
- Addition wraps mod 256. There is no carry flag.
- FSM states: IDLE, FETCH, DECODE, FETCH_IMM, IMM, EXEC, HALT.
  - IDLE: the reset state. Unconditionally → FETCH.
  - FETCH: `imem_addr` = pc, `imem_rd` = 1. → DECODE.
  - DECODE: `ir` <= `imem_data`, pc <= pc+1. Next state is chosen combinationally from `imem_data[7:5]`:
    - NOP → FETCH, with `retire`.
    - HALT → HALT, with `retire`.
    - LDI/ADDI/JMP → FETCH_IMM.
    - all others → EXEC.
  - FETCH_IMM: `imem_addr` = pc, `imem_rd` = 1. → IMM.
  - IMM: `imm` <= `imem_data`.
    - JMP: pc <= `imem_data`, `retire`, → FETCH.
    - otherwise: pc <= pc+1, → EXEC.
  - EXEC: drive `alu_b`/`alu_ctrl` per the opcode. At the clock edge, write `alu_out` to acc (or reg[r] for STR), assert `retire`, → FETCH.
  - HALT: terminal. The only exit is `rst`. `halted` = 1; no ROM reads; acc, pc and regs are frozen.
- Outside EXEC, `alu_b` = 0 and `alu_ctrl` = 0.
- Outside FETCH and FETCH_IMM, `imem_rd` = 0 and `imem_addr` = pc.
- pc increments wrap 8'hFF → 8'h00. A 2-byte instruction at 8'hFF takes its operand from 8'h00.

## Timing
- Reset values, applied asynchronously while `rst` is high:
  - state IDLE
  - pc, acc, ir, imm, reg[0..3] = 8'h00
  - all outputs 0: `imem_rd`, `alu_b`, `alu_ctrl`, `retire`, `halted`, `imem_addr`
- First FETCH is the second rising edge after `rst` deasserts (IDLE occupies one cycle).
- Cycles per instruction, from FETCH through the `retire` cycle inclusive:
  - NOP: 2
  - HALT: 2
  - LDR/ADDR/STR: 3
  - JMP: 4
  - LDI/ADDI: 5
- `retire` is registered-state-decoded and is high for exactly one cycle per instruction.
- `acc`/reg updates are visible on the cycle after EXEC.
- `rst` asserted in any state, including mid-EXEC or HALT, aborts immediately. No partial write of acc or regs may occur from the edge coinciding with reset assertion.
- `alu_out` is sampled only at the EXEC edge. Its value in other states is don't-care and must not affect any state.

## Test plan
- Reset then ROM {8'h20 (LDI), 8'h05, 8'h40 (ADDI), 8'hFC, 8'hE0 (HALT)} → acc = 8'h05 then 8'h01 (wrap). `halted` = 1 with pc = 8'h05; exactly 3 `retire` pulses; `imem_rd` stays 0 afterward.
- LDI 8'h3C; STR r2 (8'hA2); LDI 8'h01; ADDR r2 (8'h82) → reg[2] = 8'h3C, final acc = 8'h3D. During the ADDR EXEC cycle, `alu_b` = 8'h3C and `alu_ctrl` = 1.
- JMP 8'hFF (bytes 8'hC0, 8'hFF); at 8'hFF place LDI, at 8'h00 place 8'h20 → pc wraps to 8'h00; acc = 8'h20 after LDI retires.
- Cycle count: NOP, LDR r0, LDI x, JMP → `retire` gaps of 2, 3, 5 and 4 cycles measured from each FETCH. There is one IDLE cycle after reset.
- Assert `rst` during the EXEC of ADDI 8'h10 with acc = 8'h07 → acc reads 8'h00 (not 8'h17). All outputs are 0 during reset; after release, the first `imem_rd` with `imem_addr` = 8'h00 occurs 2 cycles later.
- Instruction 8'h7F (LDR, ignored bits set, r = 3) with reg[3] = 8'hAA → acc = 8'hAA. Bits [4:2] have no effect.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: fetch/decode/execute controller for the 8-bit processor.
// Reads instruction bytes from a synchronous ROM, drives the external ALU's
// operand/control inputs and captures the ALU result into the accumulator or
// one of four general registers.
//
// ROM handshake: imem_rd is a one-cycle read strobe with imem_addr held at pc;
// the ROM returns the byte on imem_data in the following cycle (DECODE or IMM),
// where it is consumed unconditionally. There is no back-pressure.
module alu_sequencer (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] imem_addr,
  output logic       imem_rd,
  input  logic [7:0] imem_data,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_ctrl,
  input  logic [7:0] alu_out,
  output logic [7:0] acc,
  output logic [7:0] pc,
  output logic       retire,
  output logic       halted
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_FETCH_IMM = 3'd3,
    S_IMM       = 3'd4,
    S_EXEC      = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_LDI  = 3'd1;
  localparam logic [2:0] OP_ADDI = 3'd2;
  localparam logic [2:0] OP_LDR  = 3'd3;
  localparam logic [2:0] OP_ADDR = 3'd4;
  localparam logic [2:0] OP_STR  = 3'd5;
  localparam logic [2:0] OP_JMP  = 3'd6;
  localparam logic [2:0] OP_HALT = 3'd7;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] imm_q, imm_d;
  // Only the opcode and register index of the instruction byte are kept;
  // bits [4:2] carry no meaning and are dropped at decode.
  logic [2:0] ir_op_q, ir_op_d;
  logic [1:0] ir_r_q, ir_r_d;
  logic [7:0] reg_q [4];
  logic [7:0] reg_d [4];

  logic       retire_c;
  logic [7:0] alu_b_c;
  logic       alu_ctrl_c;
  logic [2:0] dec_op;

  assign dec_op = imem_data[7:5];

  // State and datapath registers; reset aborts any in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= 8'h00;
      acc_q   <= 8'h00;
      imm_q   <= 8'h00;
      ir_op_q <= 3'd0;
      ir_r_q  <= 2'd0;
      for (int i = 0; i < 4; i++) reg_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      imm_q   <= imm_d;
      ir_op_q <= ir_op_d;
      ir_r_q  <= ir_r_d;
      for (int i = 0; i < 4; i++) reg_q[i] <= reg_d[i];
    end
  end

  // Next-state, register updates and the retire pulse.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    acc_d    = acc_q;
    imm_d    = imm_q;
    ir_op_d  = ir_op_q;
    ir_r_d   = ir_r_q;
    reg_d    = reg_q;
    retire_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_op_d = dec_op;
        ir_r_d  = imem_data[1:0];
        pc_d    = pc_q + 8'd1;
        // Routing is taken from the ROM byte directly so single-byte
        // NOP/HALT retire here without a separate EXEC cycle.
        case (dec_op)
          OP_NOP: begin
            retire_c = 1'b1;
            state_d  = S_FETCH;
          end
          OP_HALT: begin
            retire_c = 1'b1;
            state_d  = S_HALT;
          end
          OP_LDI, OP_ADDI, OP_JMP: begin
            state_d = S_FETCH_IMM;
          end
          default: begin
            state_d = S_EXEC;
          end
        endcase
      end
      S_FETCH_IMM: begin
        state_d = S_IMM;
      end
      S_IMM: begin
        imm_d = imem_data;
        if (ir_op_q == OP_JMP) begin
          pc_d     = imem_data;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else begin
          pc_d    = pc_q + 8'd1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // alu_out is only trusted here; every architectural write goes
        // through the ALU, including the register store.
        if (ir_op_q == OP_STR) begin
          reg_d[ir_r_q] = alu_out;
        end else begin
          acc_d = alu_out;
        end
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ALU operand B and function select; quiet (pass 0) outside EXEC.
  always_comb begin
    alu_b_c    = 8'h00;
    alu_ctrl_c = 1'b0;
    if (state_q == S_EXEC) begin
      case (ir_op_q)
        OP_LDI: begin
          alu_b_c = imm_q;
        end
        OP_ADDI: begin
          alu_b_c    = imm_q;
          alu_ctrl_c = 1'b1;
        end
        OP_LDR: begin
          alu_b_c = reg_q[ir_r_q];
        end
        OP_ADDR: begin
          alu_b_c    = reg_q[ir_r_q];
          alu_ctrl_c = 1'b1;
        end
        OP_STR: begin
          alu_b_c = acc_q;
        end
        default: begin
          alu_b_c    = 8'h00;
          alu_ctrl_c = 1'b0;
        end
      endcase
    end
  end

  assign imem_addr = pc_q;
  assign imem_rd   = (state_q == S_FETCH) || (state_q == S_FETCH_IMM);
  assign alu_a     = acc_q;
  assign alu_b     = alu_b_c;
  assign alu_ctrl  = alu_ctrl_c;
  assign acc       = acc_q;
  assign pc        = pc_q;
  assign retire    = retire_c;
  assign halted    = (state_q == S_HALT);

endmodule
